// File: rtl/sdram_disp_fetch.sv
// Display read-out stage: streams the RGB565 frame buffer from the SDRAM arbiter read port
// into a small prefetch FIFO and hands one pixel per pix_req strobe to the TFT timing block.
module sdram_disp_fetch #(
  parameter logic [23:0] FB_BASE     = 24'h000000,
  parameter int unsigned FRAME_PIX   = 130560,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [15:0] UNDER_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        frame_start_i,
  input  logic        pix_req_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  output logic        underrun_o,
  output logic        rd_req_o,
  output logic [23:0] rd_addr_o,
  input  logic        rd_done_i,
  input  logic [15:0] rd_data_i
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [23:0] LastAddr = FB_BASE + 24'(FRAME_PIX - 1);
  localparam logic [FIFO_AW-1:0] PtrOne = FIFO_AW'(1);
  localparam logic [FIFO_AW:0] LvlOne = (FIFO_AW + 1)'(1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q;
  logic                rd_req_q, discard_q;
  logic [23:0]         rd_addr_q, cur_addr_q, cur_addr_next;
  logic [15:0]         mem_q [Depth];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    level_q;
  logic [15:0]         pix_data_q;
  logic                pix_valid_q, underrun_q;
  logic                fifo_empty, fifo_full, done_ok, push, pop;

  always_comb begin
    fifo_empty    = (level_q == '0);
    fifo_full     = level_q[FIFO_AW];
    // A completing read whose frame was restarted underneath it is dropped.
    done_ok       = (state_q == StReq) && rd_done_i && !discard_q;
    push          = done_ok && !frame_start_i;
    pop           = pix_req_i && !fifo_empty;
    cur_addr_next = (cur_addr_q == LastAddr) ? FB_BASE : cur_addr_q + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rd_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= FB_BASE;
      cur_addr_q  <= FB_BASE;
      discard_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // Pixel side reads the pre-flush FIFO even in a frame_start cycle.
      pix_valid_q <= pix_req_i;
      if (pix_req_i) begin
        if (fifo_empty) begin
          pix_data_q <= UNDER_COLOR;
          underrun_q <= 1'b1;
        end else begin
          pix_data_q <= mem_q[rd_ptr_q];
        end
      end

      if (frame_start_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        case ({push, pop})
          2'b10:   level_q <= level_q + LvlOne;
          2'b01:   level_q <= level_q - LvlOne;
          default: level_q <= level_q;
        endcase
      end

      if (frame_start_i) cur_addr_q <= FB_BASE;
      else if (done_ok)  cur_addr_q <= cur_addr_next;

      case (state_q)
        StIdle: begin
          if (en_i && !fifo_full && !frame_start_i) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= cur_addr_q;
            state_q   <= StReq;
          end
        end
        StReq: begin
          // The arbiter transaction cannot be aborted; a restart only marks it for discard.
          if (rd_done_i) begin
            rd_req_q  <= 1'b0;
            discard_q <= 1'b0;
            state_q   <= StIdle;
          end else if (frame_start_i) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_data_o  = pix_data_q;
  assign pix_valid_o = pix_valid_q;
  assign underrun_o  = underrun_q;
  assign rd_req_o    = rd_req_q;
  assign rd_addr_o   = rd_addr_q;

endmodule

// File: tb/tb_sdram_disp_fetch.sv
// Scoreboard bench for sdram_disp_fetch: directed stimulus pushes expected pixels and request
// addresses; monitors pop and compare. Frame size is reduced so the address wrap is reachable.
module tb_sdram_disp_fetch;

  localparam int unsigned FramePix = 64;

  logic        clk, rst_n, en, frame_start, pix_req;
  logic [15:0] pix_data;
  logic        pix_valid, underrun, rd_req;
  logic [23:0] rd_addr;
  logic        rd_done;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;
  int exp_pix[$];
  int exp_addr[$];

  sdram_disp_fetch #(
    .FB_BASE    (24'h000000),
    .FRAME_PIX  (FramePix),
    .FIFO_AW    (4),
    .UNDER_COLOR(16'hF800)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .frame_start_i(frame_start),
    .pix_req_i    (pix_req),
    .pix_data_o   (pix_data),
    .pix_valid_o  (pix_valid),
    .underrun_o   (underrun),
    .rd_req_o     (rd_req),
    .rd_addr_o    (rd_addr),
    .rd_done_i    (rd_done),
    .rd_data_i    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbiter model: rd_done three cycles after a request is seen, data = address[15:0].
  initial begin : arbiter
    bit          pending;
    int          cnt;
    logic [23:0] lat;
    pending = 1'b0;
    cnt     = 0;
    lat     = '0;
    rd_done = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_done = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        cnt++;
        if (cnt == 3) begin
          rd_done = 1'b1;
          rd_data = lat[15:0];
          pending = 1'b0;
        end
      end else if (rd_req) begin
        pending = 1'b1;
        cnt     = 0;
        lat     = rd_addr;
      end
    end
  end

  initial begin : monitor
    logic        req_prev;
    logic [23:0] addr_prev;
    req_prev  = 1'b0;
    addr_prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pix_valid) begin
          if (exp_pix.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected: got 0x%0h with no pixel expected", pix_data);
          end else begin
            chk("pix_data", int'(pix_data), exp_pix.pop_front());
          end
        end
        if (rd_req && !req_prev) begin
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr 0x%0h with no request expected", rd_addr);
          end else begin
            chk("rd_addr", int'(rd_addr), exp_addr.pop_front());
          end
        end else if (rd_req && req_prev) begin
          chk("rd_addr_hold", int'(rd_addr), int'(addr_prev));
        end
      end
      req_prev  = rd_req;
      addr_prev = rd_addr;
    end
  end

  task automatic pix(input int v);
    exp_pix.push_back(v);
    pix_req = 1'b1;
    @(negedge clk);
    pix_req = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc);
    int n = 0;
    while ((exp_addr.size() != 0 || rd_req) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL wait_quiet: got %0d requests outstanding expected 0 after %0d cycles",
               exp_addr.size(), max_cyc);
    end
    repeat (10) @(negedge clk);
    chk("pix_drained", exp_pix.size(), 0);
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_n       = 1'b0;
    en          = 1'b0;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pop from empty FIFO with fetch disabled.
    pix(16'hF800);
    chk("underrun_set", int'(underrun), 1);

    // Fill: exactly 16 requests then idle.
    for (int i = 0; i < 16; i++) exp_addr.push_back(i);
    en = 1'b1;
    wait_quiet(400);
    chk("idle_when_full", int'(rd_req), 0);

    // Four back-to-back pops, refill with 16..19.
    for (int i = 16; i < 20; i++) exp_addr.push_back(i);
    for (int i = 0; i < 4; i++) pix(i);
    wait_quiet(200);
    chk("underrun_sticky", int'(underrun), 1);

    // Drain to level 5, then collide a push with a pop.
    en = 1'b0;
    for (int i = 4; i < 15; i++) pix(i);
    exp_addr.push_back(20);
    en = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    pix(15);
    for (int i = 16; i < 21; i++) pix(i);
    pix(16'hF800);
    wait_quiet(100);

    // Restart the frame while the read of address 40 is outstanding.
    for (int i = 21; i < 37; i++) exp_addr.push_back(i);
    en = 1'b1;
    wait_quiet(400);
    for (int i = 37; i < 41; i++) exp_addr.push_back(i);
    for (int i = 0; i < 16; i++) exp_addr.push_back(i);
    for (int i = 21; i < 25; i++) pix(i);
    n = 0;
    while (!(rd_req && rd_addr == 24'd40) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("saw_req_40", int'(rd_req && rd_addr == 24'd40), 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("req_held", int'(rd_req), 1);
    chk("addr_held", int'(rd_addr), 40);
    wait_quiet(400);
    exp_addr.push_back(16);
    pix(0);

    // Stream across the end of the frame; addresses must wrap to the base.
    for (int k = 1; k <= 70; k++) begin
      exp_addr.push_back((16 + k) % FramePix);
      pix(k % FramePix);
      repeat (5) @(negedge clk);
    end
    wait_quiet(400);
    chk("underrun_final", int'(underrun), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
